// File: rtl/exe_muldiv_pkg.sv
// Shared types and helpers for the EXE-stage multiply/divide unit.
package mips_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_t;

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/exe_muldiv_if.sv
// Operand/control bundle from ID/EXE into the mul/div unit, plus its results.
interface exe_muldiv_if;
  import mips_pkg::*;

  logic        op_valid;
  muldiv_op_t  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, rs_val, rt_val,
    input  stall, done, hi, lo
  );

  modport slave (
    input  op_valid, op, rs_val, rt_val,
    output stall, done, hi, lo
  );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on magnitudes, sign
// correction in a single FIX cycle, results held in architectural HI/LO.
module exe_muldiv
  import mips_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input  logic         clk,
  input  logic         rst,
  exe_muldiv_if.slave  bus
);

  localparam logic [1:0] S_IDLE = MD_IDLE;
  localparam logic [1:0] S_BUSY = MD_BUSY;
  localparam logic [1:0] S_FIX  = MD_FIX;
  localparam logic [1:0] S_DONE = MD_DONE;
  localparam int         CW     = $clog2(ITER + 1);

  logic [1:0]    state_q, state_d;
  muldiv_op_t    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   opa_q, opa_d;   // multiplicand, or divisor
  logic [63:0]   acc_q, acc_d;   // product accumulator, or dividend/quotient in [31:0]
  logic [32:0]   rem_q, rem_d;
  logic          rs_neg_q, rs_neg_d;
  logic          rt_neg_q, rt_neg_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic          in_signed;
  logic [31:0]   rs_abs, rt_abs;
  logic [32:0]   mul_sum;
  logic [63:0]   mul_next;
  logic [33:0]   div_diff;
  logic          div_ge;
  logic [63:0]   prod_fix;
  logic [31:0]   quo_fix, rem_fix;

  assign in_signed = ~bus.op[0];
  assign rs_abs    = (in_signed && bus.rs_val[31]) ? abs32(bus.rs_val) : bus.rs_val;
  assign rt_abs    = (in_signed && bus.rt_val[31]) ? abs32(bus.rt_val) : bus.rt_val;

  // Shift-add: the carry out of the upper half is shifted back in at bit 63.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring step: bring in the next dividend bit and try to subtract.
  assign div_diff = {rem_q, acc_q[31]} - {2'b00, opa_q};
  assign div_ge   = ~div_diff[33];

  assign prod_fix = (rs_neg_q ^ rt_neg_q) ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix  = (rs_neg_q ^ rt_neg_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = rs_neg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    rs_neg_d = rs_neg_q;
    rt_neg_d = rt_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          op_d     = bus.op;
          rs_neg_d = in_signed & bus.rs_val[31];
          rt_neg_d = in_signed & bus.rt_val[31];
          opa_d    = bus.op[1] ? rt_abs : rs_abs;
          acc_d    = {32'd0, bus.op[1] ? rs_abs : rt_abs};
          rem_d    = 33'd0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          rem_d = div_ge ? div_diff[32:0] : {rem_q[31:0], acc_q[31]};
          acc_d = {32'd0, acc_q[30:0], div_ge};
        end else begin
          acc_d = mul_next;
        end
        if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q[1]) begin
          // A zero divisor leaves rem = |dividend|, so the sign fix restores rs_val.
          hi_d = op_q[0] ? rem_q[31:0] : rem_fix;
          if (opa_q == 32'd0)
            lo_d = 32'hFFFF_FFFF;
          else
            lo_d = op_q[0] ? acc_q[31:0] : quo_fix;
        end else begin
          hi_d = op_q[0] ? acc_q[63:32] : prod_fix[63:32];
          lo_d = op_q[0] ? acc_q[31:0]  : prod_fix[31:0];
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      opa_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      rs_neg_q <= 1'b0;
      rt_neg_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      rs_neg_q <= rs_neg_d;
      rt_neg_q <= rt_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.stall = ((state_q == S_IDLE) && bus.op_valid) ||
                     (state_q == S_BUSY) || (state_q == S_FIX);
  assign bus.done  = (state_q == S_DONE);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
